weight_mem_loader: RTL and testbench
====================================

// Module: weight_mem_loader
// PURPOSE
//  Byte-stream command sequencer that configures the M x N weight/delay memory. Parses a host byte stream
//  (valid/ready) into WRITE-burst and FILL commands and drives the memory write port (addr, data, we).
//  Sits between the host serial/byte front-end and the memory macro; the SNN core reads only after done.
// PARAMETERS
//  M   320  memory depth (entries); AW = $clog2(M) = 9 at default
//  N   8    memory word width; fixed at 8 (one stream byte per word)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   synchronous active-low reset
//  in_data    in   8   host byte
//  in_valid   in   1   host byte valid
//  in_ready   out  1   loader accepts byte; transfer = in_valid & in_ready
//  abort      in   1   drop current command, return to IDLE
//  err_clear  in   1   clear sticky err
//  mem_addr   out  AW  memory address
//  mem_data   out  N   memory write data
//  mem_we     out  1   memory write enable (one write per cycle)
//  busy       out  1   state != IDLE
//  done       out  1   1-cycle pulse after final write of a command
//  err        out  1   sticky error flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; mem_addr=0, mem_data=0, mem_we=0, in_ready=0 for that cycle,
//   busy=0, done=0, err=0. First cycle after reset: in_ready=1.
//  Command frame: CMD, ADDR_HI, ADDR_LO, LEN, payload. CMD[7:6]: 00 NOP, 01 WRITE, 10 FILL, 11 illegal.
//   start = {ADDR_HI,ADDR_LO}[AW-1:0] (upper bits ignored); count = LEN+1 (1..256).
//  States: IDLE -> (CMD 01/10) A_HI -> A_LO -> LEN -> WDATA (WRITE) | FVAL (FILL) -> FRUN -> IDLE.
//   NOP: stays IDLE, no done. CMD 11: err<=1, stays IDLE.
//  WRITE: WDATA accepts count bytes; byte accepted in cycle k -> mem_we=1, mem_addr/mem_data valid in k+1.
//   in_ready=1 throughout WDATA; gaps in in_valid simply stall; no write without a transfer.
//  FILL: FVAL accepts one value byte, then FRUN: in_ready=0, mem_we=1 for count consecutive cycles,
//   same data, incrementing address; first write the cycle after the value byte is accepted.
//  Address: increments after each write; M-1 -> 0 (wrap, no error).
//  Range: start >= M -> err<=1; payload still consumed (WRITE) / run still timed (FILL) with mem_we forced 0;
//   done still pulses. Keeps framing aligned.
//  done: asserted the cycle after the last mem_we cycle of WRITE/FILL (or its suppressed equivalent).
//  in_ready: 1 in IDLE, A_HI, A_LO, LEN, WDATA, FVAL; 0 in FRUN and during reset.
//  abort: highest priority after reset; next cycle state=IDLE, mem_we=0, no done; writes already issued stand.
//  err_clear and an err-setting event in the same cycle: set wins (err=1).
//  mem_we is registered; mem_addr/mem_data hold last value when mem_we=0.
//  busy = (state != IDLE); registered, same timing as state.
// STRUCTURE
//  Package snn_mem_ctrl_pkg: opcode localparams (OP_NOP/OP_WRITE/OP_FILL/OP_ILL), state enum, CMD field slices.
//  One sub-module: mod_m_counter #(M) (load, inc, value) for the wrapping address; remainder is one FSM
//  plus an 8-bit remaining-count register.
// TESTING
//  WRITE at 5, LEN=2, bytes AA,BB,CC back-to-back -> mem_we at addr 5,6,7 data AA,BB,CC; done 1 cycle after.
//  FILL at 318, LEN=3, value 3C -> in_ready=0 4 cycles; writes addr 318,319,0,1 = 3C; done; in_ready back to 1.
//  WRITE at 400 (>=M), LEN=1, 2 bytes -> err=1, no mem_we, done pulses; next NOP/WRITE parses correctly.
//  CMD=C0 -> err=1, stays IDLE; err_clear same cycle as second C0 -> err remains 1; then err_clear -> 0.
//  WRITE LEN=3 with abort after 2nd byte -> 2 writes only, IDLE next cycle, no done; rst_n=0 mid-FILL -> all outputs reset values.
//  Random in_valid gaps during WRITE LEN=255 -> exactly 256 writes, addresses contiguous with wrap, scoreboard matches.

Source files
------------

// File: rtl/snn_mem_ctrl_pkg.sv
// Shared definitions for the weight/delay memory loader: command opcodes,
// parser state encoding and the CMD byte field helpers.
package snn_mem_ctrl_pkg;

   // Opcode carried in CMD[7:6]
   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   localparam int CMD_OP_HI = 7;
   localparam int CMD_OP_LO = 6;

   typedef enum logic [2:0] {
      S_IDLE,
      S_A_HI,
      S_A_LO,
      S_LEN,
      S_WDATA,
      S_FVAL,
      S_FRUN
   } state_t;

   function automatic logic [1:0] cmd_op(input logic [7:0] cmd);
      return cmd[CMD_OP_HI:CMD_OP_LO];
   endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Loadable modulo-M counter; supplies the wrapping memory write address.
module mod_m_counter #(
   parameter int M = 320,
   parameter int W = $clog2(M)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] LAST = W'(M - 1);

   logic [W-1:0] value_q, value_d;

   // Next value: load has priority over increment; M-1 wraps to 0
   always_comb begin
      // NOTE: default assignment first so every path assigns value_d and no latch is inferred.
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (inc) begin
         value_d = (value_q == LAST) ? '0 : value_q + W'(1);
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      if (!rst_n) value_q <= '0;
      else        value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: rtl/weight_mem_loader.sv
// Byte-stream command sequencer: parses WRITE/FILL frames from the host
// stream and drives the write port of the M x N weight/delay memory.
module weight_mem_loader
   import snn_mem_ctrl_pkg::*;
#(
   parameter int M  = 320,
   parameter int N  = 8,
   parameter int AW = $clog2(M)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          abort,
   input  logic          err_clear,
   output logic [AW-1:0] mem_addr,
   output logic [N-1:0]  mem_data,
   output logic          mem_we,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [AW:0] M_EXT = (AW + 1)'(M);

   state_t        state_q, state_d;
   logic [7:0]    hi_q, hi_d;
   logic [AW-1:0] start_q, start_d;
   logic [7:0]    rem_q, rem_d;          // writes still owed after the current one
   logic          first_q, first_d;      // next WRITE byte loads the address counter
   logic          oor_q, oor_d;          // start >= M: run is timed but writes suppressed
   logic          is_fill_q, is_fill_d;
   logic          mem_we_q, mem_we_d;
   logic [N-1:0]  mem_data_q, mem_data_d;
   logic          done_pend_q, done_pend_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          in_ready_q, in_ready_d;
   logic          busy_q, busy_d;

   logic          xfer;
   logic          err_set;
   logic          cnt_load, cnt_inc;
   logic [15:0]   addr16;
   logic [AW-1:0] lo_start;

   assign xfer     = in_valid & in_ready_q;
   assign addr16   = {hi_q, in_data};
   assign lo_start = addr16[AW-1:0];

   mod_m_counter #(.M(M), .W(AW)) u_addr_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (start_q),
      .inc      (cnt_inc),
      .value    (mem_addr)
   );

   // Frame parser and write sequencer next-state logic
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      start_d     = start_q;
      rem_d       = rem_q;
      first_d     = first_q;
      oor_d       = oor_q;
      is_fill_d   = is_fill_q;
      mem_we_d    = 1'b0;
      mem_data_d  = mem_data_q;
      done_pend_d = 1'b0;
      done_d      = done_pend_q;
      err_set     = 1'b0;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;

      if (abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (xfer) begin
               case (cmd_op(in_data))
                  OP_WRITE: begin is_fill_d = 1'b0; state_d = S_A_HI; end
                  OP_FILL:  begin is_fill_d = 1'b1; state_d = S_A_HI; end
                  OP_ILL:   err_set = 1'b1;
                  default:  ;
               endcase
            end
            S_A_HI: if (xfer) begin
               hi_d    = in_data;
               state_d = S_A_LO;
            end
            S_A_LO: if (xfer) begin
               start_d = lo_start;
               oor_d   = ({1'b0, lo_start} >= M_EXT);
               err_set = oor_d;
               state_d = S_LEN;
            end
            S_LEN: if (xfer) begin
               rem_d   = in_data;
               first_d = 1'b1;
               state_d = is_fill_q ? S_FVAL : S_WDATA;
            end
            S_WDATA: if (xfer) begin
               if (!oor_q) begin
                  mem_we_d   = 1'b1;
                  mem_data_d = in_data;
                  cnt_load   = first_q;
                  cnt_inc    = ~first_q;
               end
               first_d = 1'b0;
               if (rem_q == 8'd0) begin
                  state_d     = S_IDLE;
                  done_pend_d = 1'b1;
               end else begin
                  rem_d = rem_q - 8'd1;
               end
            end
            S_FVAL: if (xfer) begin
               if (!oor_q) begin
                  mem_we_d   = 1'b1;
                  mem_data_d = in_data;
                  cnt_load   = 1'b1;
               end
               state_d = S_FRUN;
            end
            S_FRUN: begin
               if (rem_q == 8'd0) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  rem_d = rem_q - 8'd1;
                  if (!oor_q) begin
                     mem_we_d = 1'b1;
                     cnt_inc  = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A setting event wins over a simultaneous clear
      err_d      = (err_q & ~err_clear) | err_set;
      in_ready_d = (state_d != S_FRUN);
      busy_d     = (state_d != S_IDLE);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         hi_q        <= '0;
         start_q     <= '0;
         rem_q       <= '0;
         first_q     <= 1'b0;
         oor_q       <= 1'b0;
         is_fill_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_data_q  <= '0;
         done_pend_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         start_q     <= start_d;
         rem_q       <= rem_d;
         first_q     <= first_d;
         oor_q       <= oor_d;
         is_fill_q   <= is_fill_d;
         mem_we_q    <= mem_we_d;
         mem_data_q  <= mem_data_d;
         done_pend_q <= done_pend_d;
         done_q      <= done_d;
         err_q       <= err_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready = in_ready_q;
   assign mem_data = mem_data_q;
   assign mem_we   = mem_we_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// Self-checking bench for weight_mem_loader: directed frames plus randomized
// commands, scored against an expected write list built from the command rules.
module tb_weight_mem_loader;

   localparam int M  = 320;
   localparam int N  = 8;
   localparam int AW = $clog2(M);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [N-1:0]  data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          abort;
   logic          err_clear;
   logic [AW-1:0] mem_addr;
   logic [N-1:0]  mem_data;
   logic          mem_we;
   logic          busy;
   logic          done;
   logic          err;

   int   n_checks = 0;
   int   n_errors = 0;
   int   done_cnt = 0;
   wr_t  got_q[$];
   wr_t  exp_q[$];
   logic [7:0] pl_buf [0:255];

   weight_mem_loader #(.M(M), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .abort     (abort),
      .err_clear (err_clear),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Observe the write port and done pulses mid-cycle
   always @(negedge clk) begin
      if (mem_we) got_q.push_back('{mem_addr, mem_data});
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one byte at a negedge and hold it until it is accepted
   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      int t;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_nwr"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check({tag, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   // Reference: expected writes for one command, from the frame rules
   task automatic model_cmd(input logic [7:0] cmd, input logic [15:0] a16, input logic [7:0] len,
                            output bit oor);
      int s;
      bit is_fill;
      is_fill = (cmd[7:6] == 2'b10);
      s   = int'(a16) % (1 << AW);
      oor = (s >= M);
      if (!oor)
         for (int i = 0; i <= int'(len); i++)
            exp_q.push_back('{AW'((s + i) % M), is_fill ? pl_buf[0] : pl_buf[i]});
   endtask

   task automatic run_cmd(input logic [7:0] cmd, input logic [15:0] a16, input logic [7:0] len,
                          input int max_gap, input string tag);
      int d0;
      int t;
      bit oor;
      model_cmd(cmd, a16, len, oor);
      d0 = done_cnt;
      send_byte(cmd, max_gap);
      send_byte(a16[15:8], max_gap);
      send_byte(a16[7:0], max_gap);
      send_byte(len, max_gap);
      if (cmd[7:6] == 2'b10) send_byte(pl_buf[0], max_gap);
      else for (int i = 0; i <= int'(len); i++) send_byte(pl_buf[i], max_gap);
      t = 0;
      while (done_cnt == d0 && t < 600) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      check({tag, "_done"}, done_cnt - d0, 1);
      check({tag, "_err"}, {31'd0, err}, {31'd0, oor});
      check({tag, "_idle"}, {31'd0, busy}, 0);
      compare_writes(tag);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
   endtask

   initial begin
      int  d0;
      bit  oor;
      logic [7:0] op;

      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; abort = 1'b0; err_clear = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 0);
      check("rst_we",       {31'd0, mem_we},   0);
      check("rst_addr",     32'(mem_addr),     0);
      check("rst_data",     32'(mem_data),     0);
      check("rst_busy",     {31'd0, busy},     0);
      check("rst_done",     {31'd0, done},     0);
      check("rst_err",      {31'd0, err},      0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, in_ready}, 1);

      // WRITE at 5, three back-to-back bytes: exact write and done timing
      pl_buf[0] = 8'hAA; pl_buf[1] = 8'hBB; pl_buf[2] = 8'hCC;
      model_cmd(8'h40, 16'd5, 8'd2, oor);
      send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'h05, 0); send_byte(8'h02, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
      check("w5_last_we",   {31'd0, mem_we}, 1);
      check("w5_last_addr", 32'(mem_addr), 7);
      check("w5_last_data", 32'(mem_data), 32'hCC);
      check("w5_done_early", {31'd0, done}, 0);
      @(negedge clk);
      check("w5_done",    {31'd0, done},   1);
      check("w5_we_off",  {31'd0, mem_we}, 0);
      @(negedge clk);
      check("w5_done_pulse", {31'd0, done}, 0);
      compare_writes("w5");

      // FILL at 318, 4 words wrapping past M-1
      pl_buf[0] = 8'h3C;
      model_cmd(8'h80, 16'd318, 8'd3, oor);
      send_byte(8'h80, 0); send_byte(8'h01, 0); send_byte(8'h3E, 0); send_byte(8'h03, 0);
      send_byte(8'h3C, 0);
      for (int i = 0; i < 4; i++) begin
         check("f318_ready", {31'd0, in_ready}, 0);
         check("f318_we",    {31'd0, mem_we},   1);
         check("f318_addr",  32'(mem_addr), 32'((318 + i) % M));
         check("f318_data",  32'(mem_data), 32'h3C);
         @(negedge clk);
      end
      check("f318_ready_back", {31'd0, in_ready}, 1);
      check("f318_done",       {31'd0, done},     1);
      check("f318_err",        {31'd0, err},      0);
      @(negedge clk);
      compare_writes("f318");

      // Out-of-range WRITE: payload consumed, no writes, done and err
      pl_buf[0] = 8'h11; pl_buf[1] = 8'h22;
      run_cmd(8'h40, 16'd400, 8'd1, 0, "w400");

      // NOP then a normal WRITE to confirm framing
      d0 = done_cnt;
      send_byte(8'h00, 0);
      repeat (3) @(negedge clk);
      check("nop_busy", {31'd0, busy}, 0);
      check("nop_no_done", done_cnt - d0, 0);
      pl_buf[0] = 8'h5A;
      run_cmd(8'h40, 16'd10, 8'd0, 0, "w10");

      // Illegal command and err_clear colliding with a second one
      send_byte(8'hC0, 0);
      check("ill_err",  {31'd0, err},  1);
      check("ill_busy", {31'd0, busy}, 0);
      err_clear = 1'b1;
      send_byte(8'hC0, 0);
      err_clear = 1'b0;
      check("ill_set_wins", {31'd0, err}, 1);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      check("ill_cleared", {31'd0, err}, 0);

      // Abort after the second payload byte of a 4-byte WRITE
      pl_buf[0] = 8'hD1; pl_buf[1] = 8'hD2;
      exp_q.push_back('{AW'(20), 8'hD1});
      exp_q.push_back('{AW'(21), 8'hD2});
      send_byte(8'h40, 0); send_byte(8'h00, 0); send_byte(8'd20, 0); send_byte(8'd3, 0);
      send_byte(8'hD1, 0); send_byte(8'hD2, 0);
      check("abort_we", {31'd0, mem_we}, 1);
      d0 = done_cnt;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle",  {31'd0, busy},   0);
      check("abort_we_off", {31'd0, mem_we}, 0);
      repeat (5) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      compare_writes("abort");

      // Reset in the middle of a long FILL
      pl_buf[0] = 8'h77;
      for (int i = 0; i < 5; i++) exp_q.push_back('{AW'(100 + i), 8'h77});
      send_byte(8'h80, 0); send_byte(8'h00, 0); send_byte(8'd100, 0); send_byte(8'd50, 0);
      send_byte(8'h77, 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_ready", {31'd0, in_ready}, 0);
      check("mrst_we",    {31'd0, mem_we},   0);
      check("mrst_addr",  32'(mem_addr),     0);
      check("mrst_data",  32'(mem_data),     0);
      check("mrst_busy",  {31'd0, busy},     0);
      check("mrst_done",  {31'd0, done},     0);
      check("mrst_err",   {31'd0, err},      0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_ready_back", {31'd0, in_ready}, 1);
      compare_writes("mrst");

      // Full 256-byte WRITE with random gaps, wrapping near the top
      for (int i = 0; i < 256; i++) pl_buf[i] = 8'($urandom);
      run_cmd(8'h40, 16'($urandom_range(M - 1, M - 100)), 8'd255, 3, "w256");

      // Random WRITE/FILL commands, any 16-bit address
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < 256; i++) pl_buf[i] = 8'($urandom);
         op = ($urandom_range(1, 0) == 0) ? 8'h40 : 8'h80;
         op[5:0] = 6'($urandom);
         run_cmd(op, 16'($urandom), 8'($urandom_range(40, 0)), 2, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
